mipi_csi_packet_decoder_8b4lane: RTL

- Sits between the 4-lane byte/lane aligner and the RAW depacker.
- Parses the CSI-2 packet header from the first aligned 32-bit word, decodes short packets into frame start/end pulses, and forwards RAW10/12/14 long-packet payload to the depacker.
- Forwards exactly ceil(WC/4) words as a continuous valid burst, with packet type presented ahead of the burst.
- Strips the CRC footer and any trailing bytes.

---
 rtl/mipi_csi_packet_decoder_8b4lane.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mipi_csi_packet_decoder_8b4lane.sv
// -----------------------------------------------------------------------------
// mipi_csi_packet_decoder_8b4lane
//
// Purpose:
//   CSI-2 packet decoder sitting between the 4-lane byte aligner and the RAW
//   depacker. The first aligned word of every packet is parsed as the packet
//   header. Short packets with DT 0x00/0x01 produce frame start/end pulses.
//   RAW10/12/14 long packets (DT 0x2B/0x2C/0x2D) have exactly ceil(WC/4)
//   payload words forwarded as one continuous valid burst. The CRC footer and
//   any trailing filler are discarded.
//
// Ports:
//   clk_i           byte clock, single clock domain
//   reset_n_i       asynchronous active-low reset
//   data_valid_i    aligner valid, high from header word to end of packet
//   data_i          aligned bytes, lane0 = [7:0] ... lane3 = [31:24]
//   output_valid_o  payload word valid, continuous for the whole burst
//   data_o          payload word, same byte order as data_i
//   packet_type_o   DI[2:0] of the last accepted RAW long packet
//   frame_start_o   one-cycle pulse on short packet DT 0x00
//   frame_end_o     one-cycle pulse on short packet DT 0x01
//   packet_error_o  one-cycle pulse when a long packet is truncated
//
// Configuration:
//   MIPI_PACKET_DECODER_VC_FILTER_EN  when defined, packets whose virtual
//   channel differs from VIRTUAL_CHANNEL are silently drained. When undefined
//   the virtual channel field is ignored.
// -----------------------------------------------------------------------------
module mipi_csi_packet_decoder_8b4lane #(
    parameter int unsigned MIPI_GEAR       = 8,
    parameter int unsigned LANES           = 4,
    parameter logic [1:0]  VIRTUAL_CHANNEL = 2'd0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         data_valid_i,
    input  logic [MIPI_GEAR*LANES-1:0]   data_i,
    output logic                         output_valid_o,
    output logic [MIPI_GEAR*LANES-1:0]   data_o,
    output logic [2:0]                   packet_type_o,
    output logic                         frame_start_o,
    output logic                         frame_end_o,
    output logic                         packet_error_o
);

    localparam int unsigned DATA_W = MIPI_GEAR * LANES;
    localparam int unsigned CNT_W  = 16;

    // Bytes consumed from the word count by one forwarded payload word.
    localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(DATA_W / 8);

    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_RAW10       = 6'h2B;
    localparam logic [5:0] DT_RAW12       = 6'h2C;
    localparam logic [5:0] DT_RAW14       = 6'h2D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remaining_next;

    logic               output_valid_next;
    logic [DATA_W-1:0]  data_next;
    logic [2:0]         packet_type_next;
    logic               frame_start_next;
    logic               frame_end_next;
    logic               packet_error_next;

    // Header field views of the current input word.
    logic [7:0]         hdr_di;
    logic [5:0]         hdr_dt;
    logic [1:0]         hdr_vc;
    logic [CNT_W-1:0]   hdr_wc;
    logic               hdr_is_raw;
    logic               vc_match;
    logic               vc_ok;

    // Header decode, only meaningful in the first valid cycle after IDLE.
    always_comb begin
        hdr_di     = data_i[7:0];
        hdr_dt     = hdr_di[5:0];
        hdr_vc     = hdr_di[7:6];
        hdr_wc     = {data_i[23:16], data_i[15:8]};
        hdr_is_raw = (hdr_dt == DT_RAW10) || (hdr_dt == DT_RAW12) ||
                     (hdr_dt == DT_RAW14);
        vc_match   = (hdr_vc == VIRTUAL_CHANNEL);
`ifdef MIPI_PACKET_DECODER_VC_FILTER_EN
        vc_ok      = vc_match;
`else
        // Every virtual channel is accepted in this build.
        vc_ok      = vc_match | 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next        = state;
        remaining_next    = remaining;
        output_valid_next = 1'b0;
        data_next         = data_o;
        packet_type_next  = packet_type_o;
        frame_start_next  = 1'b0;
        frame_end_next    = 1'b0;
        packet_error_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (data_valid_i) begin
                    if (!vc_ok) begin
                        state_next = ST_DRAIN;
                    end else if (hdr_dt == DT_FRAME_START) begin
                        frame_start_next = 1'b1;
                        state_next       = ST_DRAIN;
                    end else if (hdr_dt == DT_FRAME_END) begin
                        frame_end_next = 1'b1;
                        state_next     = ST_DRAIN;
                    end else if (hdr_is_raw && (hdr_wc != '0)) begin
                        // Type is published one cycle before the first payload word.
                        packet_type_next = hdr_di[2:0];
                        remaining_next   = hdr_wc;
                        state_next       = ST_PAYLOAD;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (data_valid_i) begin
                    output_valid_next = 1'b1;
                    data_next         = data_i;
                    remaining_next    = (remaining > WORD_BYTES) ?
                                        (remaining - WORD_BYTES) : '0;
                    // Partial last word passes through; depacker ignores spare bytes.
                    if (remaining <= WORD_BYTES) begin
                        state_next = ST_DRAIN;
                    end
                end else begin
                    // Valid dropped before the burst completed.
                    packet_error_next = (remaining != '0);
                    remaining_next    = '0;
                    state_next        = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Discard CRC and filler until the aligner closes the packet.
                if (!data_valid_i) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                remaining_next = '0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and output flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            remaining      <= '0;
            output_valid_o <= 1'b0;
            data_o         <= '0;
            packet_type_o  <= 3'd0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            packet_error_o <= 1'b0;
        end else begin
            remaining      <= remaining_next;
            output_valid_o <= output_valid_next;
            data_o         <= data_next;
            packet_type_o  <= packet_type_next;
            frame_start_o  <= frame_start_next;
            frame_end_o    <= frame_end_next;
            packet_error_o <= packet_error_next;
        end
    end

endmodule
